// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM states, datapath width.
package div_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} div_state_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring shift/subtract register pair: one quotient bit per step.
module div_iter_core
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem,
  output logic [XLEN-1:0] quo
);

  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   temp;
  logic [XLEN:0]   diff;

  // Partial remainder kept one bit wider so divisors with bit 63 set still compare correctly.
  always_comb begin
    temp = {rem, quo[XLEN-1]};
    diff = temp - {1'b0, dvs};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= temp[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Divide sequencer: operand prep, special cases, iteration count, sign fix-up, result hold.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            stallreq
);

  div_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic            neg_q, neg_r, is_rem, word_q;

  logic            signed_op, sa, sb, b_zero, ovf, accept, special, load, step;
  logic [31:0]     a_abs32, b_abs32;
  logic [63:0]     a_abs64, b_abs64, ld_dividend, ld_divisor, a_op, sp_res;
  logic [63:0]     q_fix, r_fix, sel, fix_res;
  logic [63:0]     rem, quo;

  assign req_ready  = rst_n & (state == StIdle) & ~flush;
  assign resp_valid = (state == StDone);
  assign stallreq   = rst_n & ((req_valid & (state == StIdle)) | (state != StIdle));
  assign accept     = req_valid & req_ready;

  always_comb begin
    signed_op   = (req_op == DIV_OP_DIV) | (req_op == DIV_OP_REM);
    sa          = signed_op & (req_word ? req_a[31] : req_a[63]);
    sb          = signed_op & (req_word ? req_b[31] : req_b[63]);
    a_abs32     = sa ? -req_a[31:0] : req_a[31:0];
    b_abs32     = sb ? -req_b[31:0] : req_b[31:0];
    a_abs64     = sa ? -req_a : req_a;
    b_abs64     = sb ? -req_b : req_b;
    // W ops iterate on the dividend parked in the upper half, 32 steps only.
    ld_dividend = req_word ? {a_abs32, 32'b0} : a_abs64;
    ld_divisor  = req_word ? {32'b0, b_abs32} : b_abs64;
    b_zero      = req_word ? (req_b[31:0] == 32'b0) : (req_b == 64'b0);
    ovf         = signed_op & (req_word
                  ? ((req_a[31:0] == 32'h8000_0000) & (req_b[31:0] == 32'hFFFF_FFFF))
                  : ((req_a == 64'h8000_0000_0000_0000) & (&req_b)));
    special     = b_zero | ovf;
    a_op        = req_word ? sext32(req_a[31:0]) : req_a;
    if (req_op[1]) sp_res = b_zero ? a_op : 64'b0;
    else           sp_res = b_zero ? 64'hFFFF_FFFF_FFFF_FFFF : a_op;
    load        = accept & ~special;
    step        = (state == StCalc);
  end

  always_comb begin
    q_fix   = neg_q ? -quo : quo;
    r_fix   = neg_r ? -rem : rem;
    sel     = is_rem ? r_fix : q_fix;
    fix_res = word_q ? sext32(sel[31:0]) : sel;
  end

  div_iter_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .dividend (ld_dividend),
    .divisor  (ld_divisor),
    .rem      (rem),
    .quo      (quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      is_rem    <= 1'b0;
      word_q    <= 1'b0;
      resp_data <= '0;
    end else if (flush) begin
      state <= StIdle;
      cnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            is_rem <= req_op[1];
            word_q <= req_word;
            if (special) begin
              resp_data <= sp_res;
              state     <= StDone;
            end else begin
              cnt   <= req_word ? CNT_W'(32) : CNT_W'(XLEN);
              state <= StCalc;
            end
          end
        end
        StCalc: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= StFix;
        end
        StFix: begin
          resp_data <= fix_res;
          state     <= StDone;
        end
        StDone: begin
          if (resp_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table plus hold, flush and reset sequences.
module tb_div_ctrl;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, req_valid, req_ready, req_word;
  logic        resp_valid, resp_ready, stallreq;
  logic [1:0]  req_op;
  logic [63:0] req_a, req_b, resp_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_word   (req_word),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .stallreq   (stallreq)
  );

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] op, logic word, logic [63:0] a, logic [63:0] b,
                              logic [63:0] exp, int lat, string name);
    vec_t v;
    v.op = op; v.word = word; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drives a request from mid-cycle; the handshake happens on the next posedge.
  task automatic send(logic [1:0] op, logic word, logic [63:0] a, logic [63:0] b, string name);
    req_valid = 1'b1; req_op = op; req_word = word; req_a = a; req_b = b;
    @(negedge clk);
    chk({name, " req_ready"}, 64'(req_ready), 64'd1);
    chk({name, " stallreq@T"}, 64'(stallreq), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output logic stall_ok);
    lat = 0;
    stall_ok = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (!stallreq) stall_ok = 1'b0;
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic take();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic run_op(logic [1:0] op, logic word, logic [63:0] a, logic [63:0] b,
                        logic [63:0] exp, int exp_lat, string name);
    int   lat;
    logic ok;
    send(op, word, a, b, name);
    wait_resp(lat, ok);
    chk({name, " data"}, resp_data, exp);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " stallreq busy"}, 64'(ok), 64'd1);
    take();
  endtask

  initial begin
    int          lat;
    logic        ok;
    logic        seen;
    logic [63:0] held;

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 2'd0; req_word = 1'b0; req_a = '0; req_b = '0;
    #1;
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset stallreq", 64'(stallreq), 64'd0);
    chk("reset resp_data", resp_data, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    sync();

    vecs.push_back(mk(DIV_OP_DIVU, 0, 64'd100, 64'd7, 64'd14, 66, "divu 100/7"));
    vecs.push_back(mk(DIV_OP_REMU, 0, 64'd100, 64'd7, 64'd2, 66, "remu 100/7"));
    vecs.push_back(mk(DIV_OP_DIV, 0, -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66, "div -100/7"));
    vecs.push_back(mk(DIV_OP_REM, 0, -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, "rem -100/7"));
    vecs.push_back(mk(DIV_OP_DIV, 0, -64'd100, -64'd7, 64'd14, 66, "div -100/-7"));
    vecs.push_back(mk(DIV_OP_REM, 0, -64'd100, -64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, "rem -100/-7"));
    vecs.push_back(mk(DIV_OP_DIV, 1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF,
                      64'hFFFF_FFFF_8000_0000, 1, "divw ovf"));
    vecs.push_back(mk(DIV_OP_REM, 1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF, 64'd0, 1, "remw ovf"));
    vecs.push_back(mk(DIV_OP_DIVU, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu by 0"));
    vecs.push_back(mk(DIV_OP_REMU, 0, 64'h1234, 64'd0, 64'h1234, 1, "remu by 0"));
    vecs.push_back(mk(DIV_OP_DIVU, 1, 64'h1234, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
                      "divuw by 0"));
    vecs.push_back(mk(DIV_OP_DIV, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                      64'h8000_0000_0000_0000, 1, "div ovf"));
    vecs.push_back(mk(DIV_OP_DIV, 1, 64'hFFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 34,
                      "divw -20/3"));
    vecs.push_back(mk(DIV_OP_REM, 1, 64'hFFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 34,
                      "remw -20/3"));
    vecs.push_back(mk(DIV_OP_DIVU, 1, 64'hFFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 34,
                      "divuw max/2"));
    vecs.push_back(mk(DIV_OP_DIVU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 66,
                      "divu big"));
    vecs.push_back(mk(DIV_OP_REMU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                      64'h7FFF_FFFF_FFFF_FFFE, 66, "remu big"));

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
             vecs[i].name);

    // Consumer stalls in DONE for five cycles, then a back-to-back op follows.
    send(DIV_OP_DIVU, 0, 64'd1000, 64'd7, "hold");
    wait_resp(lat, ok);
    chk("hold data", resp_data, 64'd142);
    held = resp_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold resp_data stable", resp_data, 64'd142);
      chk("hold resp_valid", 64'(resp_valid), 64'd1);
      chk("hold req_ready low", 64'(req_ready), 64'd0);
    end
    take();
    run_op(DIV_OP_REMU, 0, 64'd1000, 64'd7, 64'd6, 66, "back-to-back remu");

    // Flush in CALC cycle 20 must suppress the response.
    send(DIV_OP_DIVU, 0, 64'd5000, 64'd3, "flush calc");
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("flush no resp_valid", 64'(seen), 64'd0);
    chk("flush back to idle", 64'(req_ready), 64'd1);

    // Flush coincident with a request: not accepted.
    sync();
    req_valid = 1'b1; flush = 1'b1; req_op = DIV_OP_DIVU; req_word = 1'b0;
    req_a = 64'd50; req_b = 64'd5;
    @(negedge clk);
    chk("flush+req req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush+req not accepted", 64'(stallreq), 64'd0);
    sync();
    run_op(DIV_OP_DIVU, 0, 64'd1000, 64'd10, 64'd100, 66, "divu after flush");

    // Flush in DONE with resp_ready high drops the result.
    send(DIV_OP_DIVU, 0, 64'd9, 64'd3, "flush done");
    wait_resp(lat, ok);
    chk("flush done data", resp_data, 64'd3);
    resp_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush done resp_valid", 64'(resp_valid), 64'd0);
    chk("flush done idle", 64'(req_ready), 64'd1);

    // Reset mid-CALC clears everything immediately.
    sync();
    send(DIV_OP_DIVU, 0, 64'd1000, 64'd10, "reset calc");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset resp_valid", 64'(resp_valid), 64'd0);
    chk("midreset stallreq", 64'(stallreq), 64'd0);
    chk("midreset req_ready", 64'(req_ready), 64'd0);
    chk("midreset resp_data", resp_data, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    sync();
    run_op(DIV_OP_DIV, 0, 64'd7, -64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, "div 7/-2 after reset");
    run_op(DIV_OP_REM, 0, 64'd7, -64'd2, 64'd1, 66, "rem 7/-2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
